// File: rtl/ultrasonic_echo_emu_core.sv
// HC-SR04-style echo emulator: answers a trig pulse with a programmable-width echo
// after a fixed burst delay, plus MMIO control/status registers.
module ultrasonic_echo_emu_core #(
  parameter int unsigned CLK_MHZ     = 100,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned DELAY_US    = 250,
  parameter int unsigned MAX_ECHO_US = 38000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        trig,
  output logic        echo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_DELAY = 2'd2,
    S_ECHO  = 2'd3
  } state_t;

  localparam int unsigned   PW         = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_MHZ - 1);
  localparam logic [15:0]   MIN_WIDTH  = 16'(MIN_TRIG_US * CLK_MHZ);
  localparam logic [15:0]   DELAY_LAST = 16'(DELAY_US - 1);
  localparam logic [15:0]   NO_OBJ_US  = 16'(MAX_ECHO_US);

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_trig_s;
  logic          r_trig_s_d;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_us_cnt;
  logic [15:0]   r_width;
  logic [15:0]   r_len;
  logic [1:0]    r_ctrl;
  logic [15:0]   r_echo_us;
  logic [15:0]   r_echo_cnt;
  logic [7:0]    r_drop_cnt;
  logic          r_echo;

  logic w_rise;
  logic w_fall;
  logic w_tick;
  logic w_en;
  logic w_wr;
  logic w_clr_cnt;
  logic w_inc_echo;
  logic w_inc_drop;
  logic w_latch;
  logic w_clr_width;
  logic w_unused;

  assign w_rise    = r_trig_s & ~r_trig_s_d;
  assign w_fall    = ~r_trig_s & r_trig_s_d;
  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_en      = r_ctrl[0];
  assign w_wr      = cs & write;
  assign w_clr_cnt = w_wr && (addr == 5'd3);
  assign w_unused  = ^{read, wr_data[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Enable drop aborts every busy state without touching the counters.
  always_comb begin
    w_next      = r_state;
    w_inc_echo  = 1'b0;
    w_inc_drop  = 1'b0;
    w_latch     = 1'b0;
    w_clr_width = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && w_en) begin
          w_next      = S_ARM;
          w_clr_width = 1'b1;
        end
      end
      S_ARM: begin
        if (!w_en) begin
          w_next = S_IDLE;
        end else if (w_fall) begin
          if (r_width >= MIN_WIDTH) begin
            w_next  = S_DELAY;
            w_latch = 1'b1;
          end else begin
            w_next     = S_IDLE;
            w_inc_drop = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (!w_en) begin
          w_next = S_IDLE;
        end else begin
          w_inc_drop = w_rise;
          if (w_tick && (r_us_cnt == DELAY_LAST)) begin
            if (r_len == '0) begin
              w_next     = S_IDLE;
              w_inc_echo = 1'b1;
            end else begin
              w_next = S_ECHO;
            end
          end
        end
      end
      S_ECHO: begin
        if (!w_en) begin
          w_next = S_IDLE;
        end else begin
          w_inc_drop = w_rise;
          if (w_tick && (r_us_cnt == r_len - 16'd1)) begin
            w_next     = S_IDLE;
            w_inc_echo = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_trig_s   <= 1'b0;
      r_trig_s_d <= 1'b0;
      r_presc    <= '0;
      r_us_cnt   <= '0;
      r_width    <= '0;
      r_len      <= '0;
      r_ctrl     <= '0;
      r_echo_us  <= '0;
      r_echo_cnt <= '0;
      r_drop_cnt <= '0;
      r_echo     <= 1'b0;
    end else begin
      r_sync1    <= trig;
      r_trig_s   <= r_sync1;
      r_trig_s_d <= r_trig_s;

      if (w_next != r_state) begin
        r_presc  <= '0;
        r_us_cnt <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_us_cnt <= r_us_cnt + 16'd1;
      end

      if (w_clr_width) begin
        r_width <= '0;
      end else if ((r_state == S_ARM) && r_trig_s && (r_width != 16'hFFFF)) begin
        r_width <= r_width + 16'd1;
      end

      if (w_latch) r_len <= r_ctrl[1] ? NO_OBJ_US : r_echo_us;

      // Echo follows the state one cycle late; an enable drop still kills it on the next edge.
      r_echo <= (r_state == S_ECHO) && w_en;

      if (w_wr && (addr == 5'd0)) r_ctrl    <= wr_data[1:0];
      if (w_wr && (addr == 5'd1)) r_echo_us <= wr_data[15:0];

      if (w_clr_cnt) begin
        r_echo_cnt <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_inc_echo) r_echo_cnt <= r_echo_cnt + 16'd1;
        if (w_inc_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data[1:0]  = r_ctrl;
      5'd1:    rd_data[15:0] = r_echo_us;
      5'd2:    rd_data = {5'd0, r_state, (r_state != S_IDLE), r_drop_cnt, r_echo_cnt};
      default: rd_data = '0;
    endcase
  end

  assign echo = r_echo;

endmodule

// File: tb/tb_ultrasonic_echo_emu_core.sv
// Directed bench for ultrasonic_echo_emu_core, scaled to 4 cycles/us so every
// scenario fits in a few thousand clocks.
module tb_ultrasonic_echo_emu_core;

  localparam int unsigned CLK_MHZ = 4;
  localparam int unsigned LIMIT   = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        trig;
  logic        echo;

  int n_cmp = 0;
  int n_bad = 0;
  int n_edges;
  int hi_cnt;

  ultrasonic_echo_emu_core #(
    .CLK_MHZ(CLK_MHZ),
    .MIN_TRIG_US(10),
    .DELAY_US(25),
    .MAX_ECHO_US(300)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .read(read),
    .write(write),
    .addr(addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .trig(trig),
    .echo(echo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_edges++;
    if (echo === 1'b1) hi_cnt++;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic pulse(input int cyc);
    trig = 1'b1;
    repeat (cyc) begin @(posedge clk); #1; end
    trig = 1'b0;
  endtask

  // First edge after trig was dropped is edge 0 of the delay measurement.
  task automatic start_e0();
    n_edges = 0;
    hi_cnt  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_rise();
    while (echo !== 1'b1 && n_edges < LIMIT) tick();
    hi_cnt = (echo === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_fall();
    int g;
    g = 0;
    while (echo === 1'b1 && g < LIMIT) begin tick(); g++; end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; trig = 1'b0;
    n_edges = 0; hi_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_echo", {31'd0, echo}, 32'd0);
    rd_chk("reset_status", 5'd2, 32'h0000_0000);
    rd_chk("reset_ctrl", 5'd0, 32'h0000_0000);

    wr(5'd0, 32'hFFFF_FFFF);
    rd_chk("ctrl_mask", 5'd0, 32'h0000_0003);
    wr(5'd1, 32'hABCD_1234);
    rd_chk("echo_us_mask", 5'd1, 32'h0000_1234);
    wr(5'd7, 32'h1234_5678);
    rd_chk("unmapped_rd", 5'd7, 32'h0000_0000);

    // Normal 100 us echo from a 12 us trigger
    wr(5'd0, 32'd1);
    wr(5'd1, 32'd100);
    pulse(48);
    start_e0();
    finish_rise();
    chk("t1_delay", n_edges, 32'd103);
    wait_fall();
    chk("t1_width", hi_cnt, 32'd400);
    repeat (5) tick();
    rd_chk("t1_status", 5'd2, 32'h0000_0001);

    // Short 5 us trigger is dropped
    wr(5'd3, 32'd0);
    pulse(20);
    hi_cnt = 0;
    repeat (150) tick();
    chk("t2_no_echo", hi_cnt, 32'd0);
    rd_chk("t2_status", 5'd2, 32'h0001_0000);

    // No-object mode with a retrigger during echo
    wr(5'd3, 32'd0);
    wr(5'd0, 32'd3);
    wr(5'd1, 32'd50);
    pulse(48);
    start_e0();
    finish_rise();
    chk("t3_delay", n_edges, 32'd103);
    repeat (100) tick();
    trig = 1'b1;
    repeat (48) tick();
    trig = 1'b0;
    rd_chk("t3_status_busy", 5'd2, 32'h0701_0000);
    wait_fall();
    chk("t3_width", hi_cnt, 32'd1200);
    repeat (5) tick();
    rd_chk("t3_status_end", 5'd2, 32'h0001_0001);

    // Enable cleared mid-echo, then a normal pulse with a late echo_us write
    wr(5'd3, 32'd0);
    wr(5'd0, 32'd1);
    wr(5'd1, 32'd100);
    pulse(48);
    start_e0();
    finish_rise();
    chk("t4_delay", n_edges, 32'd103);
    repeat (10) tick();
    wr(5'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("t4_abort_echo", {31'd0, echo}, 32'd0);
    rd_chk("t4_abort_status", 5'd2, 32'h0000_0000);
    wr(5'd0, 32'd1);
    pulse(48);
    start_e0();
    tick();
    tick();
    wr(5'd1, 32'd5);
    n_edges++;
    finish_rise();
    chk("t4_re_delay", n_edges, 32'd103);
    wait_fall();
    chk("t4_re_width", hi_cnt, 32'd400);
    repeat (5) tick();
    rd_chk("t4_status", 5'd2, 32'h0000_0001);

    // Zero-length echo counts without pulsing; counter clear
    wr(5'd3, 32'd0);
    wr(5'd1, 32'd0);
    pulse(48);
    hi_cnt = 0;
    repeat (200) tick();
    chk("t5_no_echo", hi_cnt, 32'd0);
    rd_chk("t5_status", 5'd2, 32'h0000_0001);
    wr(5'd3, 32'd0);
    rd_chk("t5_cleared", 5'd2, 32'h0000_0000);

    // Reset mid-echo
    wr(5'd1, 32'd100);
    pulse(48);
    start_e0();
    finish_rise();
    chk("t6_delay", n_edges, 32'd103);
    repeat (10) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_echo", {31'd0, echo}, 32'd0);
    rd_chk("t6_rst_status", 5'd2, 32'h0000_0000);
    rd_chk("t6_rst_ctrl", 5'd0, 32'h0000_0000);
    rd_chk("t6_rst_echo_us", 5'd1, 32'h0000_0000);
    reset = 1'b0;
    pulse(48);
    hi_cnt = 0;
    repeat (200) tick();
    chk("t6_disabled_echo", hi_cnt, 32'd0);
    rd_chk("t6_disabled_status", 5'd2, 32'h0000_0000);

    // drop_count saturates at 255
    wr(5'd0, 32'd1);
    wr(5'd3, 32'd0);
    repeat (260) begin
      pulse(4);
      repeat (8) tick();
    end
    rd_chk("t7_drop_sat", 5'd2, 32'h00FF_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
